// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer between display line fetch (priority) and a pixel writer
module vga_fb_arbiter #(
  parameter int WORDS_PER_LINE = 80,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int LINE_W         = 10,
  parameter int LB_AW          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_req,
  input  logic [LINE_W-1:0] line_num,
  output logic              fetch_done,
  output logic              fetch_overrun,
  output logic              busy,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [DATA_W-1:0] lb_wdata
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  logic [1:0]        state_q, state_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LB_AW-1:0]  idx_q, idx_d;
  logic              lb_we_q, lb_we_d;
  logic [LB_AW-1:0]  lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0] lb_wdata_q, lb_wdata_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              last, collide;
  // next-state: a new line request always relatches the base; one arriving over an active or pending fetch aborts it via IDLE
  always_comb begin
    last       = idx_q == LB_AW'(WORDS_PER_LINE - 1);
    collide    = line_req && (pending_q || state_q == S_FETCH);
    state_d    = state_q;
    pending_d  = pending_q;
    base_d     = base_q;
    idx_d      = idx_q;
    lb_we_d    = 1'b0;
    lb_addr_d  = '0;
    lb_wdata_d = '0;
    done_d     = 1'b0;
    overrun_d  = overrun_q || collide;
    if (line_req) begin
      base_d    = ADDR_W'(line_num * WORDS_PER_LINE);
      pending_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (pending_d) begin
          state_d   = S_FETCH;
          pending_d = 1'b0;
          idx_d     = '0;
        end else if (wr_valid) begin
          state_d = S_WRITE;
        end
      end
      S_FETCH: begin
        if (collide) begin
          state_d = S_IDLE;
        end else if (mem_ack) begin
          lb_we_d    = 1'b1;
          lb_addr_d  = idx_q;
          lb_wdata_d = mem_rdata;
          idx_d      = idx_q + 1'b1;
          done_d     = last;
          state_d    = last ? S_IDLE : S_FETCH;
        end
      end
      S_WRITE: state_d = mem_ack ? S_IDLE : S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      base_q     <= '0;
      idx_q      <= '0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_wdata_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      lb_we_q    <= lb_we_d;
      lb_addr_q  <= lb_addr_d;
      lb_wdata_q <= lb_wdata_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end
  assign mem_req       = state_q != S_IDLE;
  assign mem_we        = state_q == S_WRITE;
  assign mem_addr      = state_q == S_FETCH ? base_q + ADDR_W'(idx_q) : state_q == S_WRITE ? wr_addr : '0;
  assign mem_wdata     = state_q == S_WRITE ? wr_data : '0;
  assign wr_ready      = state_q == S_WRITE && mem_ack;
  assign busy          = state_q != S_IDLE || pending_q;
  assign fetch_done    = done_q;
  assign fetch_overrun = overrun_q;
  assign lb_we         = lb_we_q;
  assign lb_addr       = lb_addr_q;
  assign lb_wdata      = lb_wdata_q;
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer memory between two requesters:
  - display line-fetch, driven by the VGA timing generator during horizontal blanking;
  - a pixel-draw writer.
- Display fetch has absolute priority; fetched words are copied into the scan-out line buffer.
- Sits between the timing generator, line buffer, drawing logic and the memory controller, all on the dot clock.

Parameters:
- WORDS_PER_LINE, 80, memory words per displayed line (640 px at 8 px/word).
- ADDR_W, 16, memory word address width.
- DATA_W, 8, memory/line-buffer data width.
- LINE_W, 10, line-number width.
- LB_AW, 7, line-buffer address width; must satisfy 2^LB_AW >= WORDS_PER_LINE.

Ports:
- clk  in  1  dot clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- line_req  in  1  one-cycle pulse: start fetch of line line_num.
- line_num  in  LINE_W  line to fetch; sampled when line_req=1.
- fetch_done  out  1  one-cycle pulse: last word written to line buffer.
- fetch_overrun  out  1  sticky: line_req arrived while a fetch was active/pending.
- busy  out  1  high when state != IDLE or a fetch is pending.
- wr_valid  in  1  writer request.
- wr_addr  in  ADDR_W  writer address.
- wr_data  in  DATA_W  writer data.
- wr_ready  out  1  write accepted (completed) this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle for reads.
- mem_rdata  in  DATA_W  read data.
- lb_we  out  1  line-buffer write strobe.
- lb_addr  out  LB_AW  line-buffer word index.
- lb_wdata  out  DATA_W  line-buffer data.

Behaviour:
- Reset (async): state=IDLE, pending=0. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, lb_*, fetch_done, fetch_overrun, busy.
- line_req handling:
  - Sets pending and latches base = line_num*WORDS_PER_LINE, truncated to ADDR_W.
  - If pending=1 or state=FETCH when line_req arrives: set fetch_overrun, abort any fetch, relatch base, restart from word 0 on the next FETCH entry. No fetch_done for the aborted line.
- States: IDLE, FETCH, WRITE.
- IDLE transitions:
  - pending=1 -> FETCH: clear pending, idx=0.
  - else wr_valid=1 -> WRITE.
  - line_req and wr_valid in the same cycle: FETCH wins.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr=base+idx; held stable until mem_ack.
  - On mem_ack: the next cycle gives lb_we=1, lb_addr=idx, lb_wdata=captured mem_rdata.
  - If idx < WORDS_PER_LINE-1: idx+1, and mem_req stays high back-to-back with the new address in that next cycle.
  - If idx = WORDS_PER_LINE-1: mem_req=0, fetch_done=1 together with the final lb_we, -> IDLE.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - wr_ready = (state==WRITE && mem_ack), combinational. On ack -> IDLE.
  - Writes are non-preemptive: a line_req during WRITE only sets pending, and the fetch starts right after the ack.
  - Writer must hold wr_valid, wr_addr and wr_data until wr_ready.
- Dropped requests: wr_valid falling before ack is illegal; the bench flags it as an error.
- mem_req never deasserts without a preceding mem_ack, except on abort (overrun restart) or rst.
- fetch_overrun clears only on rst.
- Address arithmetic wraps modulo 2^ADDR_W.
- Minimum fetch latency: WORDS_PER_LINE cycles with zero-wait ack (ack in the first request cycle).

Test Plan:
- Idle fetch:
  - Stimulus: line_req with line_num=2, WORDS_PER_LINE=80, mem_ack every cycle.
  - Required: mem_addr sequence 160..239; lb_addr 0..79 with matching data; fetch_done exactly 1 cycle, concurrent with lb_addr=79.
- Writer alone:
  - Stimulus: wr_valid addr=0x1234 data=0xA5, ack after 3 wait cycles.
  - Required: mem_we=1, addr/data stable for 4 cycles; wr_ready single pulse on ack cycle; busy=0 after.
- Collision:
  - Stimulus: line_req and wr_valid in same IDLE cycle.
  - Required: full 80-word fetch first, wr_ready only after fetch_done.
- Line request mid-write:
  - Stimulus: line_req during a WRITE with a 5-cycle ack.
  - Required: write completes, then fetch begins the cycle after IDLE; no overrun.
- Overrun:
  - Stimulus: second line_req (line 3) at word 40 of line 2.
  - Required: fetch_overrun=1 sticky; restart at address 240; only one fetch_done.
- Reset mid-fetch:
  - Stimulus: assert rst asynchronously at word 10.
  - Required: mem_req, lb_we and busy drop immediately; no fetch_done; the next line_req starts at word 0.
